// File: rtl/pmodjstk_reader.sv
// pmodjstk_reader
//   Polls a Digilent PmodJSTK joystick over SPI mode 0 (SCLK idle low,
//   MOSI/MISO change on the falling edge and are sampled on the rising edge).
//   One frame is five bytes. Byte 0 carries the LED command and bytes 1-4
//   are zero. The five bytes received back hold the X and Y position and
//   the button state. A frame starts on a TRIG pulse, or on poll-timer
//   expiry while EN is high.
//
//   Ports
//     ACLK, ARESETN     system clock, asynchronous active-low reset
//     EN                enable periodic polling
//     TRIG              one-cycle request for a single frame
//     LED[1:0]          LED command, latched when a frame starts
//     SS_N, SCLK, MOSI  SPI master outputs
//     MISO              SPI data in (asynchronous, synchronised here)
//     X, Y[9:0]         last joystick position
//     BTN[2:0]          last button state
//     DATA_VALID        one-cycle pulse when X/Y/BTN/FRAME_CNT update
//     BUSY              high while a frame is in progress
//     FRAME_CNT[15:0]   completed frames, wrapping
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | SS_N high; wait for TRIG or poll-timer expiry
//   S_SETUP | SS_N low; SETUP_CYC cycles before the first SCLK phase
//   S_SHIFT | 8 bits of one byte, each CLK_DIV low then CLK_DIV high
//   S_GAP   | SCLK low for GAP_CYC cycles between bytes
//   S_DONE  | publish results, pulse DATA_VALID, then back to idle

module pmodjstk_reader #(
    parameter int CLK_DIV   = 50,
    parameter int SETUP_CYC = 1500,
    parameter int GAP_CYC   = 1000,
    parameter int POLL_CYC  = 1000000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        EN,
    input  logic        TRIG,
    input  logic [1:0]  LED,
    output logic        SS_N,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic [2:0]  BTN,
    output logic        DATA_VALID,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT
);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("pmodjstk_reader: CLK_DIV must be at least 4");
    end
    if (SETUP_CYC < 1 || GAP_CYC < 1 || POLL_CYC < 1) begin : g_bad_timing
        $error("pmodjstk_reader: SETUP_CYC, GAP_CYC and POLL_CYC must be at least 1");
    end

    // One down-counter serves the setup wait, the SCLK phases and the gaps,
    // so it is sized for the largest of the three.
    localparam int TMR_MAX = (SETUP_CYC > GAP_CYC)
                           ? ((SETUP_CYC > CLK_DIV) ? SETUP_CYC : CLK_DIV)
                           : ((GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV);
    localparam int TMR_W  = $clog2(TMR_MAX);
    localparam int POLL_W = $clog2(POLL_CYC + 1);

    localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0]  DIV_LOAD   = TMR_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_TC    = POLL_W'(POLL_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TMR_W-1:0]  tmr_q;
    logic [POLL_W-1:0] poll_cnt_q;
    logic              sclk_q;
    logic              ss_n_q;
    logic              mosi_q;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        byte_cnt_q;
    logic [7:0]        tx_sr_q;
    logic [6:0]        rx_sr_q;
    logic              miso_meta_q;
    logic              miso_sync_q;
    logic [7:0]        rx0_q;
    logic [1:0]        rx1_q;
    logic [7:0]        rx2_q;
    logic [1:0]        rx3_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [2:0]        btn_q;
    logic              data_valid_q;
    logic [15:0]       frame_cnt_q;

    logic       tmr_zero;
    logic       poll_expired;
    logic       start;
    logic       bit_end;
    logic       byte_end;
    logic       last_byte;
    logic       wait_end;
    logic       low_start;
    logic       frame_end;
    logic [7:0] rx_byte;

    assign tmr_zero     = (tmr_q == '0);
    assign poll_expired = (poll_cnt_q == POLL_TC);
    // TRIG and poll expiry in the same cycle still yield a single start.
    assign start        = (state_q == S_IDLE) && (TRIG || (EN && poll_expired));
    // The bit is complete at the last cycle of its high phase.
    assign bit_end      = (state_q == S_SHIFT) && sclk_q && tmr_zero;
    assign byte_end     = bit_end && (bit_cnt_q == 3'd0);
    assign last_byte    = (byte_cnt_q == 3'd4);
    assign frame_end    = byte_end && last_byte;
    assign wait_end     = ((state_q == S_SETUP) || (state_q == S_GAP)) && tmr_zero;
    // A new low phase begins when the setup or gap wait runs out, or when a
    // bit that is not the last of its byte finishes.
    assign low_start    = wait_end || (bit_end && !byte_end);
    assign rx_byte      = {rx_sr_q, miso_sync_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_SETUP;
            S_SETUP: if (tmr_zero) state_d = S_SHIFT;
            S_SHIFT: if (byte_end) state_d = last_byte ? S_DONE : S_GAP;
            S_GAP:   if (tmr_zero) state_d = S_SHIFT;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Poll timer counts up so that EN low can hold it at zero.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            poll_cnt_q <= '0;
        end else if (!EN || state_q == S_DONE) begin
            poll_cnt_q <= '0;
        end else if (state_q == S_IDLE && !poll_expired) begin
            poll_cnt_q <= poll_cnt_q + POLL_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) tmr_q <= SETUP_LOAD;
                end
                S_SETUP, S_GAP: begin
                    tmr_q <= tmr_zero ? DIV_LOAD : tmr_q - TMR_W'(1);
                end
                S_SHIFT: begin
                    if (!tmr_zero)
                        tmr_q <= tmr_q - TMR_W'(1);
                    else if (byte_end && !last_byte)
                        tmr_q <= GAP_LOAD;
                    else
                        tmr_q <= DIV_LOAD;
                end
                default: tmr_q <= tmr_q;
            endcase
        end
    end

    // SS_N follows the next state so it falls in the first SETUP cycle and
    // rises as the FSM returns to idle after DONE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            bit_cnt_q  <= 3'd7;
            byte_cnt_q <= 3'd0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 7'h00;
        end else begin
            ss_n_q <= (state_d == S_IDLE);

            // SCLK is the phase bit; the last high phase of a byte toggles
            // it back low, so it is low throughout GAP and DONE.
            if (state_q == S_SHIFT && tmr_zero)
                sclk_q <= ~sclk_q;

            if (start) begin
                tx_sr_q    <= {6'b100000, LED};
                byte_cnt_q <= 3'd0;
            end else if (low_start) begin
                mosi_q  <= tx_sr_q[7];
                tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end else if (byte_end) begin
                mosi_q     <= 1'b0;
                byte_cnt_q <= byte_cnt_q + 3'd1;
            end

            if (wait_end)
                bit_cnt_q <= 3'd7;
            else if (bit_end)
                bit_cnt_q <= bit_cnt_q - 3'd1;

            if (bit_end)
                rx_sr_q <= rx_byte[6:0];
        end
    end

    // Only the bits that reach the outputs are kept from each byte.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rx0_q <= 8'h00;
            rx1_q <= 2'b00;
            rx2_q <= 8'h00;
            rx3_q <= 2'b00;
        end else if (byte_end) begin
            case (byte_cnt_q)
                3'd0:    rx0_q <= rx_byte;
                3'd1:    rx1_q <= rx_byte[1:0];
                3'd2:    rx2_q <= rx_byte;
                3'd3:    rx3_q <= rx_byte[1:0];
                default: ;
            endcase
        end
    end

    // Results are loaded on the edge into DONE so they are visible, together
    // with DATA_VALID, during the DONE cycle itself.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            x_q          <= 10'h000;
            y_q          <= 10'h000;
            btn_q        <= 3'b000;
            data_valid_q <= 1'b0;
            frame_cnt_q  <= 16'h0000;
        end else begin
            data_valid_q <= frame_end;
            if (frame_end) begin
                x_q         <= {rx1_q, rx0_q};
                y_q         <= {rx3_q, rx2_q};
                btn_q       <= rx_byte[2:0];
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign SS_N       = ss_n_q;
    assign SCLK       = sclk_q;
    assign MOSI       = mosi_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign BTN        = btn_q;
    assign DATA_VALID = data_valid_q;
    assign BUSY       = (state_q != S_IDLE);
    assign FRAME_CNT  = frame_cnt_q;

endmodule
